// File: rtl/itransform_wht.sv
// itransform_wht -- iterative inverse 4x4 Walsh-Hadamard transform (luma DC).
// A vertical pass runs one column per clock, then a horizontal pass runs one
// row per clock with +3 rounding, arithmetic >>3 and saturation to COEF_WIDTH.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request pulse, sampled only while idle
//   in         : 16 signed coefs, coef k at [COEF_WIDTH*k +: COEF_WIDTH], k = 4*row+col
//   out        : 16 signed results, same packing; valid from the done cycle
//   busy       : high while a transform is in progress
//   done       : one-cycle pulse when the last row has been written
module itransform_wht #(
  parameter int BLOCK_SIZE = 4,   // only 4 is supported
  parameter int COEF_WIDTH = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*COEF_WIDTH-1:0]   in,
  output logic [BLOCK_SIZE*BLOCK_SIZE*COEF_WIDTH-1:0]   out,
  output logic                                          busy,
  output logic                                          done
);
  localparam int NC = BLOCK_SIZE * BLOCK_SIZE;
  localparam int CW = COEF_WIDTH;
  localparam int TW = CW + 2;   // column pass: sum of 4 inputs
  localparam int RW = CW + 4;   // row pass: sum of 16 inputs plus bias

  localparam logic signed [RW-1:0] BIAS   = RW'(3);
  localparam logic signed [RW-1:0] SAT_HI = RW'((2 ** (CW - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_LO = RW'(-(2 ** (CW - 1)));

  typedef enum logic [1:0] {S_IDLE, S_COL, S_ROW} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [NC-1:0][CW-1:0]  x_q, x_d;
  logic [NC-1:0][TW-1:0]  tmp_q, tmp_d;
  logic [NC-1:0][CW-1:0]  out_q, out_d;
  logic                   done_q, done_d;

  function automatic logic signed [TW-1:0] sx_t(input logic [CW-1:0] v);
    return {{(TW-CW){v[CW-1]}}, v};
  endfunction

  function automatic logic signed [RW-1:0] sx_r(input logic [TW-1:0] v);
    return {{(RW-TW){v[TW-1]}}, v};
  endfunction

  function automatic logic [CW-1:0] sat(input logic signed [RW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[CW-1:0];
    else if (v < SAT_LO) return SAT_LO[CW-1:0];
    else                 return v[CW-1:0];
  endfunction

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      tmp_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      tmp_q   <= tmp_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_COL;
        cnt_d   = '0;
      end
      S_COL: begin
        cnt_d = cnt_q + 2'd1;          // wraps to 0 entering ROW
        if (cnt_q == 2'd3) state_d = S_ROW;
      end
      S_ROW: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---- datapath / outputs ----
  // Column i reads x[i], x[4+i], x[8+i], x[12+i]; row i reads tmp[4i..4i+3].
  logic [3:0]             ci0, ci1, ci2, ci3, ri0, ri1, ri2, ri3;
  logic signed [TW-1:0]   ca0, ca1, ca2, ca3;
  logic signed [RW-1:0]   t0, t1, t2, t3, dc, ra0, ra1, ra2, ra3;
  logic signed [RW-1:0]   s0, s1, s2, s3;

  always_comb begin
    ci0 = {2'd0, cnt_q};
    ci1 = {2'd1, cnt_q};
    ci2 = {2'd2, cnt_q};
    ci3 = {2'd3, cnt_q};
    ri0 = {cnt_q, 2'd0};
    ri1 = {cnt_q, 2'd1};
    ri2 = {cnt_q, 2'd2};
    ri3 = {cnt_q, 2'd3};

    ca0 = sx_t(x_q[ci0]) + sx_t(x_q[ci3]);
    ca1 = sx_t(x_q[ci1]) + sx_t(x_q[ci2]);
    ca2 = sx_t(x_q[ci1]) - sx_t(x_q[ci2]);
    ca3 = sx_t(x_q[ci0]) - sx_t(x_q[ci3]);

    t0  = sx_r(tmp_q[ri0]);
    t1  = sx_r(tmp_q[ri1]);
    t2  = sx_r(tmp_q[ri2]);
    t3  = sx_r(tmp_q[ri3]);
    dc  = t0 + BIAS;   // rounding bias folded into the DC term once per row
    ra0 = dc + t3;
    ra1 = t1 + t2;
    ra2 = t1 - t2;
    ra3 = dc - t3;
    s0  = (ra0 + ra1) >>> 3;
    s1  = (ra3 + ra2) >>> 3;
    s2  = (ra0 - ra1) >>> 3;
    s3  = (ra3 - ra2) >>> 3;

    x_d    = x_q;
    tmp_d  = tmp_q;
    out_d  = out_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) x_d = in;
      S_COL: begin
        tmp_d[ci0] = ca0 + ca1;
        tmp_d[ci1] = ca3 + ca2;
        tmp_d[ci2] = ca0 - ca1;
        tmp_d[ci3] = ca3 - ca2;
      end
      S_ROW: begin
        out_d[ri0] = sat(s0);
        out_d[ri1] = sat(s1);
        out_d[ri2] = sat(s2);
        out_d[ri3] = sat(s3);
        done_d     = (cnt_q == 2'd3);
      end
      default: ;
    endcase
  end

  assign out  = out_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
endmodule

// File: tb/tb_itransform_wht.sv
// Directed bench for itransform_wht: reset, latency, rounding/saturation
// corners, random blocks against a matrix-form inverse WHT, start-while-busy,
// back-to-back start in the done cycle, and reset mid-transform.
module tb_itransform_wht;
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] in_v;
  logic [255:0] out;
  logic         busy;
  logic         done;

  int n_chk = 0;
  int n_err = 0;

  itransform_wht #(.BLOCK_SIZE(4), .COEF_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in_v),
    .out(out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hadamard basis row u, column r (row order matches the decoder output order)
  function automatic int hs(input int u, input int r);
    case (u)
      0: return 1;
      1: return (r < 2) ? 1 : -1;
      2: return (r == 0 || r == 3) ? 1 : -1;
      default: return (r[0] == 1'b0) ? 1 : -1;
    endcase
  endfunction

  // out[u][v] = sat((sum_c H[v][c] * sum_r H[u][r] * x[r][c] + 3) >>> 3)
  function automatic logic [255:0] model(input logic [255:0] v);
    int x [4][4];
    int t [4][4];
    int s;
    logic [15:0] c;
    logic [255:0] res;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      c = v[16*k +: 16];
      x[k/4][k%4] = int'($signed(c));
    end
    for (int u = 0; u < 4; u++)
      for (int cc = 0; cc < 4; cc++) begin
        t[u][cc] = 0;
        for (int r = 0; r < 4; r++) t[u][cc] += hs(u, r) * x[r][cc];
      end
    for (int u = 0; u < 4; u++)
      for (int w = 0; w < 4; w++) begin
        s = 0;
        for (int cc = 0; cc < 4; cc++) s += hs(w, cc) * t[u][cc];
        s = (s + 3) >>> 3;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        res[16*(4*u+w) +: 16] = s[15:0];
      end
    return res;
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] c);
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = c;
    return r;
  endfunction

  task automatic wait_done(output int n);
    n = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (done) begin
        n = e;
        break;
      end
    end
  endtask

  task automatic kick(input logic [255:0] v);
    @(negedge clk);
    in_v  = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_v  = ~v;   // must not affect the result
  endtask

  task automatic go(input string tag, input logic [255:0] v, input logic [255:0] exp);
    int n;
    kick(v);
    wait_done(n);
    chk({tag, "_lat"}, 256'(n), 256'd8);
    chk({tag, "_out"}, out, exp);
  endtask

  logic [255:0] v1, v2, e1, e2, ev;
  int n, ndone, nbusy;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_v  = '0;
    #1;
    chk("rst_out",  out, '0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // all zero: busy for 8 cycles, done at the 8th edge, one-cycle pulse
    kick('0);
    nbusy = busy ? 1 : 0;
    n = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (busy) nbusy++;
      if (done) begin
        n = e;
        break;
      end
    end
    chk("zero_lat",  256'(n), 256'd8);
    chk("zero_busy", 256'(nbusy), 256'd8);
    chk("zero_out",  out, '0);
    @(posedge clk); #1;
    chk("done_pulse", 256'(done), 256'd0);

    // DC only: +8 -> all 1, -8 -> all -1 (arithmetic shift)
    v1 = '0; v1[15:0] = 16'd8;
    go("dc_p8", v1, fill(16'd1));
    v1 = '0; v1[15:0] = 16'hfff8;
    go("dc_m8", v1, fill(16'hffff));

    // saturation corners
    ev = '0; ev[15:0] = 16'h7fff;
    go("sat_hi", fill(16'h7fff), ev);
    ev = '0; ev[15:0] = 16'h8000;
    go("sat_lo", fill(16'h8000), ev);

    // hand-checked mixed pattern: x0=16, x1=8 -> row 0 all from
    // t=[24,...]? column pass gives tmp[0..3]=[16,8,0,0] on every row u
    v1 = '0; v1[15:0] = 16'd16; v1[31:16] = 16'd8;
    ev = '0;
    for (int u = 0; u < 4; u++) begin
      ev[16*(4*u+0) +: 16] = 16'd3;   // (24+3)>>>3
      ev[16*(4*u+1) +: 16] = 16'd3;   // (16+8+3)>>>3
      ev[16*(4*u+2) +: 16] = 16'd1;   // (16-8+3)>>>3
      ev[16*(4*u+3) +: 16] = 16'd1;
    end
    go("mixed", v1, ev);

    // random blocks against the matrix model
    for (int i = 0; i < 1000; i++) begin
      for (int w = 0; w < 8; w++) v1[32*w +: 32] = $urandom;
      go("rand", v1, model(v1));
    end

    // start at edges 3 and 6 ignored; start in the done cycle accepted
    for (int w = 0; w < 8; w++) v1[32*w +: 32] = $urandom;
    for (int w = 0; w < 8; w++) v2[32*w +: 32] = $urandom;
    e1 = model(v1);
    e2 = model(v2);
    kick(v1);
    ndone = 0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 3 || e == 6) begin
        start = 1'b1;
        in_v  = v2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) ndone++;
    end
    chk("ign_done", 256'(done), 256'd1);
    chk("ign_cnt",  256'(ndone), 256'd1);
    chk("ign_out",  out, e1);
    start = 1'b1;                 // still in the done cycle: FSM is idle
    in_v  = v2;
    @(posedge clk); #1;
    start = 1'b0;
    in_v  = '0;
    chk("b2b_busy", 256'(busy), 256'd1);
    wait_done(n);
    chk("b2b_lat", 256'(n + 1), 256'd9);
    chk("b2b_out", out, e2);

    // reset during ROW: out cleared, busy low, no done afterwards
    kick(v1);
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_out",  out, '0);
    chk("mid_busy", 256'(busy), 256'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mid_nodone", 256'(ndone), 256'd0);
    chk("mid_idle",   256'(busy), 256'd0);
    go("post_rst", v2, e2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/itransform_wht.md
Name: itransform_wht

Overview:
Inverse 4x4 Walsh-Hadamard transform engine for the luma DC path of the decoder/reconstruction side. It is the inverse counterpart of the forward Hadamard used in the distortion path.
- Accepts 16 signed DC coefficients.
- Runs a vertical pass and then a horizontal pass, iteratively, one column or row per clock.
- Returns 16 signed DC values with rounding (+3 bias, arithmetic >>3) and saturation, ready for scatter into the 16 sub-block coefficient sets.

Parameters:
BLOCK_SIZE, 4, transform dimension; only 4 is supported.
COEF_WIDTH, 16, signed width of each input and output coefficient.

Ports:
clk     input   1     clock, rising edge
rst_n   input   1     asynchronous reset, active low
start   input   1     request pulse; sampled only when idle
in      input   256   16 signed coefs; coef k at [16k+15:16k], raster order (k = 4*row + col)
out     output  256   16 signed results, same packing
busy    output  1     high while a transform is in progress
done    output  1     one-cycle pulse; out valid from this cycle

Behaviour:
- Reset: state IDLE; out, busy, done and all internal tmp registers are 0. Reset takes effect asynchronously in any state.
- FSM states and transitions:
  - IDLE: start=1 -> latch all of in into an internal register; go to COL, counter=0.
  - COL: 4 cycles; counter 0..3 selects column i; then go to ROW, counter=0.
  - ROW: 4 cycles; counter 0..3 selects row i.
  - At the edge that writes row 3, return to IDLE and set done=1 for exactly one cycle.
- busy = (state != IDLE).
- Latency: done rises at the 8th rising edge after the edge that sampled start. Throughput is one block per 9 cycles when start is reissued during the done cycle.
- COL pass, column i, using the latched input x. tmp is 18-bit signed.
  - a0 = x[i] + x[12+i]
  - a1 = x[4+i] + x[8+i]
  - a2 = x[4+i] - x[8+i]
  - a3 = x[i] - x[12+i]
  - tmp[i] = a0+a1; tmp[4+i] = a3+a2; tmp[8+i] = a0-a1; tmp[12+i] = a3-a2
- ROW pass, row i, with t = tmp[4i..4i+3]. Intermediates are 20-bit signed.
  - dc = t0 + 3
  - a0 = dc + t3; a1 = t1 + t2; a2 = t1 - t2; a3 = dc - t3
  - r0 = (a0+a1)>>>3; r1 = (a3+a2)>>>3; r2 = (a0-a1)>>>3; r3 = (a3-a2)>>>3
  - Each r is saturated to [-32768, 32767] and written to out[4i+0..3].
- Widths: no intermediate may overflow for any 16-bit input. The extreme sums are +/-131072 after COL and +/-524288 after ROW.
- out holds its value from done until the ROW phase of the next transform. out entries may update row by row while busy; consumers read only on done.
- start while busy is ignored: no re-latch of in and no extra done.
- start in the done cycle is accepted, since the FSM is already IDLE.
- in changing after start has been sampled has no effect on the result.
- Reset mid-operation: returns to IDLE, clears out, and produces no done for the aborted transform.

Test Plan:
- All-zero in, pulse start -> busy high for 8 cycles; done pulses 8 edges after start; out all 0 (the +3 bias is removed by >>>3).
- in[0]=8, others 0 -> all 16 outputs = 1; in[0]=-8, others 0 -> all 16 outputs = -1 (checks arithmetic shift).
- All 16 in = 32767 -> out[0]=32767 (saturated from 65534); out[1..15]=0. All 16 in = -32768 -> out[0]=-32768 (saturated); out[1..15]=0.
- Random in vectors (at least 1000), compared against a software inverse-WHT model using the same equations and saturation -> bit-exact match on every done.
- start reasserted at edges 3 and 6 of a transform -> ignored; exactly one done. Then start held high in the done cycle -> second transform accepted immediately; second done 9 cycles after the first; results correct for both inputs.
- rst_n asserted during ROW (edge 6), released 2 cycles later -> out=0, busy=0, no done. A following start completes normally with the correct result.
